// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, widths, control-field positions and delay helper for the SPI path
package spi_pkg;
  localparam int DATA_W = 16;
  localparam int SS_N = 4;
  localparam int CTRL_WLS = 0;
  localparam int CTRL_CPOL = 1;
  localparam int CTRL_CPHA = 2;
  localparam int CTRL_CDTE = 3;
  localparam int CTRL_SS_LSB = 4;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, XFER, STORE, HOLD} state_t;
  function automatic logic [7:0] div_cycles(input logic [7:0] div);
    return div == 8'd0 ? 8'd1 : div;
  endfunction
endpackage

// File: rtl/spi_ss_timer.sv
// spi_ss_timer: loadable saturating down-counter whose done flag marks the last counted cycle
module spi_ss_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] val,
  output logic       done
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? val : cnt - {7'd0, cnt != 8'd0};
  assign done = cnt <= 8'd1;
endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: moves TX FIFO words through the SPI shift core into the RX FIFO with framed slave selects
module spi_xfer_ctrl #(
  parameter int DATA_W = spi_pkg::DATA_W,
  parameter int SS_N = spi_pkg::SS_N
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wls,
  input  logic              i_cdte,
  input  logic [1:0]        i_ss,
  input  logic [7:0]        i_div_val,
  input  logic              i_tx_empty,
  output logic              o_tx_rd_en,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_rx_full,
  output logic              o_rx_wr_en,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_core_start,
  output logic [DATA_W-1:0] o_core_data,
  input  logic              i_core_done,
  input  logic [DATA_W-1:0] i_core_rdata,
  output logic [SS_N-1:0]   o_ss_n,
  output logic              o_busy,
  output logic              o_frame_done
);
  import spi_pkg::*;
  state_t state, next;
  logic wls, cdte, tmr_load, tmr_done;
  logic [1:0] ss;
  logic [7:0] div;
  logic [DATA_W-1:0] tx_word, rx_word;
  assign tx_word = wls ? i_tx_data : {{(DATA_W-8){1'b0}}, i_tx_data[7:0]};
  assign rx_word = wls ? i_core_rdata : {{(DATA_W-8){1'b0}}, i_core_rdata[7:0]};
  assign tmr_load = next != state && (next == SETUP || next == HOLD);
  spi_ss_timer u_tmr (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .load (tmr_load),
    .val  (div),
    .done (tmr_done)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = i_tx_empty ? IDLE : FETCH;
      FETCH:   next = LOAD;
      LOAD:    next = &o_ss_n ? SETUP : XFER;
      SETUP:   next = tmr_done ? XFER : SETUP;
      XFER:    next = i_core_done ? STORE : XFER;
      STORE:   next = i_rx_full ? STORE : (cdte && !i_tx_empty) ? FETCH : HOLD;
      HOLD:    next = tmr_done ? IDLE : HOLD;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state        <= IDLE;
      wls          <= 1'b0;
      cdte         <= 1'b0;
      ss           <= '0;
      div          <= '0;
      o_tx_rd_en   <= 1'b0;
      o_rx_wr_en   <= 1'b0;
      o_rx_data    <= '0;
      o_core_start <= 1'b0;
      o_core_data  <= '0;
      o_ss_n       <= '1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && !i_tx_empty) {wls, cdte, ss, div} <= {i_wls, i_cdte, i_ss, div_cycles(i_div_val)};
      if (state == LOAD) o_core_data <= tx_word;
      if (state == XFER && i_core_done) o_rx_data <= rx_word;
      o_tx_rd_en   <= next == FETCH;
      o_rx_wr_en   <= state == STORE && !i_rx_full;
      o_core_start <= next == XFER && state != XFER;
      o_busy       <= next != IDLE;
      o_frame_done <= state == HOLD && next == IDLE;
      o_ss_n       <= next == SETUP ? ~(SS_N'(1) << ss) : next == IDLE ? '1 : o_ss_n;
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed checks of framing, timing, stalls and reset for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wls = 1'b0, cdte = 1'b0, tx_empty = 1'b1, rx_full = 1'b0, core_done = 1'b0;
  logic [1:0] ss = 2'd0;
  logic [7:0] div = 8'd0;
  logic [15:0] tx_data = 16'h0, core_rdata = 16'h0;
  logic tx_rd_en, rx_wr_en, core_start, busy, frame_done;
  logic [15:0] rx_data, core_data;
  logic [3:0] ss_n;
  always #5 clk = ~clk;
  spi_xfer_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wls(wls), .i_cdte(cdte), .i_ss(ss), .i_div_val(div),
    .i_tx_empty(tx_empty), .o_tx_rd_en(tx_rd_en), .i_tx_data(tx_data), .i_rx_full(rx_full),
    .o_rx_wr_en(rx_wr_en), .o_rx_data(rx_data), .o_core_start(core_start), .o_core_data(core_data),
    .i_core_done(core_done), .i_core_rdata(core_rdata), .o_ss_n(ss_n), .o_busy(busy),
    .o_frame_done(frame_done)
  );
  logic [15:0] tx_q[$], resp_q[$], rx_log[$], cd_log[$];
  int start_log[$], push_log[$];
  int cycle = 0, core_lat = 3, core_wait = 0;
  int starts, pushes, frames, rd_pulses, ss_low, ss_falls, ss_fall_c, ss_rise_c, push_c, frame_c, bad_ss = 0;
  int n_chk = 0, n_fail = 0;
  int c0, f;
  logic [3:0] ss_val, prev_ss = 4'hF;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    core_done = 1'b0;
    if (core_start) begin
      starts++;
      start_log.push_back(cycle);
      cd_log.push_back(core_data);
      core_wait = core_lat;
    end else if (core_wait > 0) begin
      core_wait--;
      if (core_wait == 0) begin
        core_done = 1'b1;
        core_rdata = resp_q.size() > 0 ? resp_q.pop_front() : 16'hDEAD;
      end
    end
    if (tx_rd_en) begin
      rd_pulses++;
      if (tx_q.size() > 0) tx_data = tx_q.pop_front();
    end
    tx_empty = tx_q.size() == 0;
    if (rx_wr_en) begin
      pushes++;
      push_c = cycle;
      push_log.push_back(cycle);
      rx_log.push_back(rx_data);
    end
    if (frame_done) begin
      frames++;
      frame_c = cycle;
    end
    if (ss_n != 4'hF) begin
      ss_low++;
      ss_val = ss_n;
      if (prev_ss == 4'hF) begin
        ss_falls++;
        ss_fall_c = cycle;
      end
    end else if (prev_ss != 4'hF) ss_rise_c = cycle;
    if ($countones(~ss_n) > 1) bad_ss++;
    prev_ss = ss_n;
  endtask
  task automatic clr();
    starts = 0; pushes = 0; frames = 0; rd_pulses = 0; ss_low = 0; ss_falls = 0;
    ss_fall_c = 0; ss_rise_c = 0; push_c = 0; frame_c = 0;
    start_log.delete(); push_log.delete(); rx_log.delete(); cd_log.delete();
  endtask
  task automatic send(input logic [15:0] w);
    tx_q.push_back(w);
    tx_empty = 1'b0;
  endtask
  task automatic wait_frame(input int lim);
    int f0 = frames;
    int n = 0;
    while (frames == f0 && n < lim) begin
      cyc();
      n++;
    end
    chk("frame_timeout", 32'(frames != f0), 1);
  endtask
  task automatic wait_start(input int lim);
    int s0 = starts;
    int n = 0;
    while (starts == s0 && n < lim) begin
      cyc();
      n++;
    end
    chk("start_timeout", 32'(starts != s0), 1);
  endtask
  initial begin
    clr();
    repeat (2) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_ss_n", ss_n, 4'hF);
    chk("rst_rd_en", tx_rd_en, 0);
    chk("rst_wr_en", rx_wr_en, 0);
    chk("rst_start", core_start, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    repeat (2) cyc();
    clr();
    wls = 1'b1; cdte = 1'b0; ss = 2'd2; div = 8'd4; core_lat = 3;
    resp_q.push_back(16'h1234);
    send(16'hA5C3);
    c0 = cycle;
    cyc();
    chk("t1_busy", busy, 1);
    chk("t1_rd_en", tx_rd_en, 1);
    cyc();
    chk("t1_rd_once", tx_rd_en, 0);
    wait_frame(100);
    chk("t1_ss_fall", ss_fall_c - c0, 3);
    chk("t1_setup", start_log[0] - ss_fall_c, 4);
    chk("t1_push_cyc", push_c - c0, 12);
    chk("t1_hold", ss_rise_c - push_c, 4);
    chk("t1_ss_low", ss_low, 13);
    chk("t1_ss_val", ss_val, 4'b1011);
    chk("t1_core_data", cd_log[0], 16'hA5C3);
    chk("t1_rx", rx_log[0], 16'h1234);
    chk("t1_frame_cyc", frame_c - c0, 16);
    chk("t1_starts", starts, 1);
    chk("t1_pushes", pushes, 1);
    chk("t1_idle_busy", busy, 0);
    cyc();
    chk("t1_frame_pulse", frame_done, 0);
    chk("t1_frames", frames, 1);
    clr();
    wls = 1'b0; ss = 2'd0; div = 8'd2;
    resp_q.push_back(16'h5A77);
    send(16'hBEEF);
    cyc();
    wls = 1'b1;
    wait_frame(100);
    chk("t2_core_data", cd_log[0], 16'h00EF);
    chk("t2_rx", rx_log[0], 16'h0077);
    chk("t2_ss_val", ss_val, 4'b1110);
    chk("t2_setup", start_log[0] - ss_fall_c, 2);
    chk("t2_hold", ss_rise_c - push_c, 2);
    clr();
    wls = 1'b1; cdte = 1'b1; ss = 2'd1; div = 8'd3;
    resp_q.push_back(16'hAAAA); resp_q.push_back(16'hBBBB); resp_q.push_back(16'hCCCC);
    send(16'h1111); send(16'h2222); send(16'h3333);
    wait_frame(300);
    cdte = 1'b0;
    chk("t3_starts", starts, 3);
    chk("t3_pushes", pushes, 3);
    chk("t3_pops", rd_pulses, 3);
    chk("t3_frames", frames, 1);
    chk("t3_ss_falls", ss_falls, 1);
    chk("t3_ss_val", ss_val, 4'b1101);
    chk("t3_cd0", cd_log[0], 16'h1111);
    chk("t3_cd2", cd_log[2], 16'h3333);
    chk("t3_rx1", rx_log[1], 16'hBBBB);
    chk("t3_rx2", rx_log[2], 16'hCCCC);
    chk("t3_gap", start_log[1] - push_log[0], 2);
    chk("t3_setup", start_log[0] - ss_fall_c, 3);
    chk("t3_hold", ss_rise_c - push_log[2], 3);
    clr();
    ss = 2'd3; div = 8'd1; core_lat = 3;
    resp_q.push_back(16'h8765);
    send(16'h4321);
    rx_full = 1'b1;
    wait_start(50);
    repeat (10) cyc();
    chk("t4_no_push", pushes, 0);
    chk("t4_ss_held", ss_n, 4'b0111);
    chk("t4_busy", busy, 1);
    rx_full = 1'b0;
    f = cycle;
    cyc();
    chk("t4_push_now", rx_wr_en, 1);
    chk("t4_push_cyc", push_c - f, 1);
    chk("t4_rx", rx_data, 16'h8765);
    wait_frame(50);
    chk("t4_pushes", pushes, 1);
    chk("t4_ss_falls", ss_falls, 1);
    chk("t4_hold", ss_rise_c - push_c, 1);
    clr();
    ss = 2'd0; div = 8'd0; core_lat = 2;
    resp_q.push_back(16'h0001);
    send(16'h0100);
    wait_frame(50);
    chk("t5_setup", start_log[0] - ss_fall_c, 1);
    chk("t5_hold", ss_rise_c - push_c, 1);
    chk("t5_rx", rx_log[0], 16'h0001);
    clr();
    ss = 2'd1; div = 8'd255; core_lat = 1;
    resp_q.push_back(16'h00FF);
    send(16'h0055);
    wait_frame(1000);
    chk("t5_setup255", start_log[0] - ss_fall_c, 255);
    chk("t5_hold255", ss_rise_c - push_c, 255);
    clr();
    ss = 2'd2; div = 8'd2; core_lat = 20;
    resp_q.push_back(16'h9999);
    send(16'h7777);
    wait_start(50);
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_ss_n", ss_n, 4'hF);
    chk("t6_busy", busy, 0);
    chk("t6_core_data", core_data, 0);
    chk("t6_rx_data", rx_data, 0);
    chk("t6_start", core_start, 0);
    chk("t6_rd_en", tx_rd_en, 0);
    core_wait = 0;
    resp_q.delete();
    tx_q.delete();
    tx_empty = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_idle", busy, 0);
    clr();
    div = 8'd1; core_lat = 3;
    resp_q.push_back(16'h1357);
    send(16'h2468);
    wait_frame(100);
    chk("t6_starts", starts, 1);
    chk("t6_cd", cd_log[0], 16'h2468);
    chk("t6_rx", rx_log[0], 16'h1357);
    chk("one_ss_low", bad_ss, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Transfer sequencer between the APB register block's TX/RX FIFOs and the SPI shift core. It pops words from the TX FIFO and frames them with slave-select setup and hold delays. It starts the shift core for each word, pushes received words into the RX FIFO, and reports busy back to the register block so it can reject configuration writes mid-transfer.

## Interface
- DATA_W, 16, FIFO/shift word width
- SS_N, 4, number of active-low slave selects (decoded from 2-bit select)
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_wls  in  1  word length: 0 = 8-bit, 1 = 16-bit
- i_cdte  in  1  continuous transfer: keep SS asserted across back-to-back words
- i_ss  in  2  slave index
- i_div_val  in  8  SS setup/hold delay in i_clk cycles (0 treated as 1)
- i_tx_empty  in  1  TX FIFO empty
- o_tx_rd_en  out  1  TX pop pulse; i_tx_data valid the following cycle
- i_tx_data  in  16  TX FIFO head
- i_rx_full  in  1  RX FIFO full
- o_rx_wr_en  out  1  RX push pulse
- o_rx_data  out  16  RX push data
- o_core_start  out  1  shift-core start pulse
- o_core_data  out  16  word to shift out
- i_core_done  in  1  shift-core done pulse
- i_core_rdata  in  16  shifted-in word, valid with i_core_done
- o_ss_n  out  SS_N  slave selects, active-low
- o_busy  out  1  high whenever state != IDLE
- o_frame_done  out  1  1-cycle pulse on return to IDLE

## Operation
- States: IDLE, FETCH, LOAD, SETUP, XFER, STORE, HOLD.
- IDLE: when i_tx_empty=0, latch i_wls, i_ss, i_div_val (frame config), go to FETCH. Config inputs are ignored until the next IDLE.
- FETCH: o_tx_rd_en=1 for exactly one cycle, then LOAD.
- LOAD: capture i_tx_data. With wls=0, o_core_data={8'h00,tx[7:0]}; otherwise the full word. Go to SETUP if SS is deasserted; if SS is already asserted (chained word), go to XFER.
- SETUP: o_ss_n[ss]=0; count max(div,1) cycles, then XFER.
- XFER: o_core_start pulses on the first cycle only. Wait for i_core_done, capture i_core_rdata (masked to 8 bits when wls=0), then STORE.
- STORE: wait while i_rx_full=1 (no push, data held). When not full: one-cycle o_rx_wr_en with o_rx_data valid. Next state: FETCH if latched cdte=1 and i_tx_empty=0; otherwise HOLD.
- HOLD: SS stays asserted for max(div,1) cycles, then o_ss_n goes to all-ones, o_frame_done pulses, and state returns to IDLE.
- i_core_done outside XFER is ignored. Only one SS line is ever low.
- i_cdte is sampled at frame start with the rest of the config.

## Timing
- All outputs are registered. Reset values: o_tx_rd_en=0, o_rx_wr_en=0, o_rx_data=0, o_core_start=0, o_core_data=0, o_ss_n=all ones, o_busy=0, o_frame_done=0. State is IDLE and counters are 0.
- i_tx_empty falls at cycle 0 → o_busy=1 and o_tx_rd_en=1 at cycle 1 → data captured at cycle 2 → SS low from cycle 3.
- o_core_start is asserted div cycles after SS goes low.
- Word-to-word gap in cdte mode: done → push (STORE, ≥1 cycle) → FETCH → LOAD → start. SS is not released between words.
- RX full during STORE: the block stalls indefinitely with SS held. No word is lost or duplicated.
- Reset mid-operation: immediate return to IDLE and reset values; SS is released asynchronously.
- The 8-bit counter saturates and never wraps. div=255 gives 255 cycles.

## Structure
- Shared package `spi_pkg`: state enum, DATA_W, register-field positions for wls/cpol/cpha/cdte/ss, and the div-to-cycles helper.
- One natural sub-module, `spi_ss_timer`: a loadable down-counter with a done flag, instantiated once and reused by SETUP and HOLD.

## Test plan
- Single 16-bit word 0xA5C3, div=4, ss=2, core returns 0x1234 → o_ss_n=4'b1011 for setup 4 + xfer + hold 4 cycles; RX push of 0x1234; one o_frame_done.
- wls=0, TX 0xBEEF, core returns 0x5A77 → o_core_data=0x00EF, o_rx_data=0x0077.
- cdte=1 with 3 queued words → SS low continuously; exactly 3 starts and 3 pushes; a single setup and hold.
- RX full asserted before done for 10 cycles → no o_rx_wr_en during the stall; push occurs 1 cycle after full drops; SS held throughout.
- div=0 → setup and hold last 1 cycle each.
- Reset asserted during XFER → all outputs at reset values immediately; a subsequent non-empty TX starts a fresh frame.
